// File: rtl/frame_tiler.sv
// Splits a frame into raster-ordered tile descriptors for a conv engine.
// Layer configuration is captured at start and held for the whole frame.
module frame_tiler #(
    parameter int unsigned TILE_ROWS  = 16,
    parameter int unsigned TILE_COLS  = 16,
    parameter int unsigned POF        = 2,
    parameter int unsigned PIF        = 3,
    parameter int unsigned MULT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [15:0]                      frame_rows,
    input  logic [15:0]                      frame_cols,
    input  logic [15:0]                      cfg_in_ch,
    input  logic [15:0]                      cfg_out_ch,
    input  logic                             cfg_is_dfconv,
    input  logic [POF*PIF*MULT_WIDTH-1:0]    cfg_mults_flat,
    input  logic                             tile_ready,
    output logic                             tile_valid,
    output logic                             is_dfconv,
    output logic [15:0]                      rows,
    output logic [15:0]                      cols,
    output logic [15:0]                      in_ch,
    output logic [15:0]                      out_ch,
    output logic [15:0]                      row_base,
    output logic [15:0]                      col_base,
    output logic [POF*PIF*MULT_WIDTH-1:0]    assigned_mults_flat,
    output logic                             last_tile,
    output logic                             busy,
    output logic                             done,
    output logic                             err_cfg
);

    localparam int unsigned MultBits = POF * PIF * MULT_WIDTH;
    localparam logic [16:0] TileRows17 = 17'(TILE_ROWS);
    localparam logic [16:0] TileCols17 = 17'(TILE_COLS);

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           frame_rows_q, frame_rows_d;
    logic [15:0]           frame_cols_q, frame_cols_d;
    logic [15:0]           in_ch_q, in_ch_d;
    logic [15:0]           out_ch_q, out_ch_d;
    logic                  is_dfconv_q, is_dfconv_d;
    logic [MultBits-1:0]   mults_q, mults_d;
    logic [15:0]           row_base_q, row_base_d;
    logic [15:0]           col_base_q, col_base_d;
    logic                  err_q, err_d;

    // 17-bit arithmetic so tiles near the 65535 edge never wrap.
    logic [16:0] row_sum, col_sum, rows_rem, cols_rem;
    logic        col_end, row_end, emit;

    assign row_sum  = {1'b0, row_base_q} + TileRows17;
    assign col_sum  = {1'b0, col_base_q} + TileCols17;
    assign rows_rem = {1'b0, frame_rows_q} - {1'b0, row_base_q};
    assign cols_rem = {1'b0, frame_cols_q} - {1'b0, col_base_q};
    assign col_end  = col_sum >= {1'b0, frame_cols_q};
    assign row_end  = row_sum >= {1'b0, frame_rows_q};
    assign emit     = (state_q == StEmit);

    always_comb begin
        state_d      = state_q;
        frame_rows_d = frame_rows_q;
        frame_cols_d = frame_cols_q;
        in_ch_d      = in_ch_q;
        out_ch_d     = out_ch_q;
        is_dfconv_d  = is_dfconv_q;
        mults_d      = mults_q;
        row_base_d   = row_base_q;
        col_base_d   = col_base_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    frame_rows_d = frame_rows;
                    frame_cols_d = frame_cols;
                    in_ch_d      = cfg_in_ch;
                    out_ch_d     = cfg_out_ch;
                    is_dfconv_d  = cfg_is_dfconv;
                    mults_d      = cfg_mults_flat;
                    row_base_d   = '0;
                    col_base_d   = '0;
                    err_d        = (frame_rows == '0) || (frame_cols == '0);
                    state_d      = err_d ? StFin : StEmit;
                end
            end
            StEmit: begin
                if (tile_ready) begin
                    if (col_end && row_end) begin
                        // Bases hold on the final tile so the descriptor stays coherent.
                        state_d = StFin;
                    end else if (col_end) begin
                        col_base_d = '0;
                        row_base_d = row_sum[15:0];
                    end else begin
                        col_base_d = col_sum[15:0];
                    end
                end
            end
            StFin: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            frame_rows_q <= '0;
            frame_cols_q <= '0;
            in_ch_q      <= '0;
            out_ch_q     <= '0;
            is_dfconv_q  <= 1'b0;
            mults_q      <= '0;
            row_base_q   <= '0;
            col_base_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_rows_q <= frame_rows_d;
            frame_cols_q <= frame_cols_d;
            in_ch_q      <= in_ch_d;
            out_ch_q     <= out_ch_d;
            is_dfconv_q  <= is_dfconv_d;
            mults_q      <= mults_d;
            row_base_q   <= row_base_d;
            col_base_q   <= col_base_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        tile_valid          = emit;
        rows                = '0;
        cols                = '0;
        if (emit) begin
            rows = (rows_rem < TileRows17) ? rows_rem[15:0] : TileRows17[15:0];
            cols = (cols_rem < TileCols17) ? cols_rem[15:0] : TileCols17[15:0];
        end
        last_tile           = emit && col_end && row_end;
        is_dfconv           = is_dfconv_q;
        in_ch               = in_ch_q;
        out_ch              = out_ch_q;
        row_base            = row_base_q;
        col_base            = col_base_q;
        assigned_mults_flat = mults_q;
        busy                = (state_q != StIdle);
        done                = (state_q == StFin);
        err_cfg             = (state_q == StFin) && err_q;
    end

endmodule
